// File: rtl/hdmi_buff_gearbox.sv
// Gearbox that serialises wide DDR read-FIFO words into HDMI pixels.
// Video timing and pixel data both travel through the same two-stage pipeline, so they stay aligned.
module hdmi_buff_gearbox #(
    parameter int FIFO_W     = 256,
    parameter int PIX_W      = 32,
    parameter int MSB_FIRST  = 1,
    parameter int LINE_ALIGN = 1
) (
    input  logic              hdmi_clk,
    input  logic              sync_rst_n,
    input  logic              hdmi_Pre_de,
    input  logic              hdmi_Pre_hsync,
    input  logic              hdmi_Pre_vsync,
    output logic              hdmi_Post_en,
    output logic              hdmi_Post_hsync,
    output logic              hdmi_Post_vsync,
    output logic [PIX_W-1:0]  hdmi_rd_data,
    output logic              fifo_rd_en,
    input  logic [FIFO_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              underflow
);

    localparam int RATIO = FIFO_W / PIX_W;
    localparam int CNT_W = $clog2(RATIO);

    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff, cnt_d1_q;
    logic              vsync_d_q, de_d1_q, hs_d1_q, vs_d1_q;
    logic [FIFO_W-1:0] word_q, src;
    logic              post_en_q, post_hs_q, post_vs_q;
    logic [PIX_W-1:0]  rd_data_q;
    logic              underflow_q, underflow_d;
    logic              vs_rise, line_end;

    function automatic logic [PIX_W-1:0] slice(input logic [FIFO_W-1:0] w,
                                               input logic [CNT_W-1:0]  c);
        logic [CNT_W-1:0] idx;
        // RATIO is a power of two, so RATIO-1-c is simply the bitwise inverse of c
        idx = (MSB_FIRST != 0) ? ~c : c;
        return w[int'(idx)*PIX_W +: PIX_W];
    endfunction

    assign vs_rise  = hdmi_Pre_vsync & ~vsync_d_q;
    assign line_end = (LINE_ALIGN != 0) & ~hdmi_Pre_de & de_d1_q;

    // A frame-start clear applies to the current cycle, so de during the vsync edge reads a fresh word.
    assign cnt_eff = vs_rise ? '0 : cnt_q;

    always_comb begin
        cnt_d = cnt_eff;
        if (hdmi_Pre_de)
            cnt_d = cnt_eff + CNT_W'(1);
        else if (line_end)
            cnt_d = '0;
    end

    assign fifo_rd_en  = hdmi_Pre_de & (cnt_eff == '0) & sync_rst_n;
    assign underflow_d = (fifo_rd_en & fifo_empty) | (underflow_q & ~vs_rise);
    assign src         = (cnt_d1_q == '0) ? fifo_rd_data : word_q;

    always_ff @(posedge hdmi_clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            cnt_q       <= '0;
            vsync_d_q   <= 1'b0;
            de_d1_q     <= 1'b0;
            hs_d1_q     <= 1'b0;
            vs_d1_q     <= 1'b0;
            cnt_d1_q    <= '0;
            word_q      <= '0;
            post_en_q   <= 1'b0;
            post_hs_q   <= 1'b0;
            post_vs_q   <= 1'b0;
            rd_data_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            vsync_d_q   <= hdmi_Pre_vsync;
            underflow_q <= underflow_d;
            // Stage 1: FIFO data of last cycle's read is on fifo_rd_data now
            de_d1_q     <= hdmi_Pre_de;
            hs_d1_q     <= hdmi_Pre_hsync;
            vs_d1_q     <= hdmi_Pre_vsync;
            cnt_d1_q    <= cnt_eff;
            if (de_d1_q && (cnt_d1_q == '0))
                word_q <= fifo_rd_data;
            // Stage 2: registered outputs
            post_en_q   <= de_d1_q;
            post_hs_q   <= hs_d1_q;
            post_vs_q   <= vs_d1_q;
            rd_data_q   <= de_d1_q ? slice(src, cnt_d1_q) : '0;
        end
    end

    assign hdmi_Post_en    = post_en_q;
    assign hdmi_Post_hsync = post_hs_q;
    assign hdmi_Post_vsync = post_vs_q;
    assign hdmi_rd_data    = rd_data_q;
    assign underflow       = underflow_q;

endmodule

// File: doc/hdmi_buff_gearbox.md
Name: hdmi_buff_gearbox

Overview:
Parametrised successor of the fixed 256-to-32 HDMI line buffer. It pulls FIFO_W-bit words from a standard (non-show-ahead) read FIFO and serialises them into PIX_W-bit pixels during active video. It delays de/hsync/vsync by the same fixed latency so timing and data stay aligned. It also adds selectable slice order, per-line or per-frame counter realignment, blanking of data outside active video, and sticky FIFO-underflow detection. It sits between the DDR read FIFO and the HDMI encoder, entirely in the hdmi_clk domain.

Parameters:
FIFO_W, 256, FIFO read data width; must be an integer multiple of PIX_W.
PIX_W, 32, output pixel width.
RATIO, FIFO_W/PIX_W, derived localparam (pixels per word); must be a power of two, at least 2.
MSB_FIRST, 1, 1 = first pixel is bits [FIFO_W-1 -: PIX_W]; 0 = first pixel is bits [PIX_W-1:0].
LINE_ALIGN, 1, 1 = slice counter clears on every de falling edge; 0 = counter clears only at frame start.

Ports:
hdmi_clk  in  1  pixel clock, all logic rising-edge.
sync_rst_n  in  1  asynchronous, active-low reset.
hdmi_Pre_de  in  1  input data-enable (active video).
hdmi_Pre_hsync  in  1  input hsync.
hdmi_Pre_vsync  in  1  input vsync, active high.
hdmi_Post_en  out  1  de delayed by 2 cycles.
hdmi_Post_hsync  out  1  hsync delayed by 2 cycles.
hdmi_Post_vsync  out  1  vsync delayed by 2 cycles.
hdmi_rd_data  out  PIX_W  serialised pixel; zero when hdmi_Post_en=0.
fifo_rd_en  out  1  FIFO read strobe; data is valid on fifo_rd_data one cycle later.
fifo_rd_data  in  FIFO_W  FIFO read data.
fifo_empty  in  1  FIFO empty flag.
underflow  out  1  sticky: a read was issued while fifo_empty=1.

Behaviour:
- Reset: all outputs 0. Internal registers 0: slice counter cnt, de/hsync/vsync delay stages, word_reg, vsync_d.
- Slice counter cnt, log2(RATIO) bits:
  - Increments (wrapping RATIO-1 -> 0) on each cycle with hdmi_Pre_de=1.
  - Forced to 0 on the vsync rising edge (Pre_vsync=1, vsync_d=0).
  - When LINE_ALIGN=1, also forced to 0 on the cycle Pre_de=0 after Pre_de=1. A partial word at line end is discarded; the next line starts with a fresh read.
  - Clear takes priority over increment.
- fifo_rd_en is combinational: Pre_de & (cnt==0). Exactly one read per RATIO active pixels.
- Stage 1 (cycle t+1):
  - Register de_d1, hs_d1, vs_d1, cnt_d1 from cycle t.
  - If de_d1 & cnt_d1==0: word_reg <= fifo_rd_data.
- Stage 2 (cycle t+2):
  - hdmi_Post_* <= stage-1 signals.
  - hdmi_rd_data <= de_d1 ? slice(src, cnt_d1) : 0, where src = fifo_rd_data when cnt_d1==0, else word_reg.
  - Slice index i = cnt_d1 when MSB_FIRST=0, RATIO-1-cnt_d1 when MSB_FIRST=1; the slice is src[i*PIX_W +: PIX_W].
- Latency: fixed 2 cycles from Pre_* to Post_* and to the matching pixel, for all parameter values.
- Underflow:
  - Set on any cycle with fifo_rd_en & fifo_empty. Data that cycle is passed through unmodified; there is no stall.
  - Cleared on the vsync rising edge unless set in the same cycle, in which case set wins.
- Line shorter than RATIO pixels (LINE_ALIGN=1): one read, the unused slices are dropped.
- de asserted across a vsync edge: counter clears and a read is issued that cycle if de=1.
- Async reset mid-line: outputs drop to 0 immediately. After release, the first de cycle issues a read; stale data is never output.
- No back-pressure exists. The upstream must keep the FIFO non-empty before de; underflow is reported only.

Test Plan:
- Defaults, 16-pixel line, FIFO words W0 = 0x00000007_00000006_..._00000000 and W1 with the 0x10 offset -> rd_en high in de cycles 0 and 8 only; Post_en rises 2 cycles after Pre_de; rd_data sequence 0x7,0x6,...,0x0,0x17,...,0x10.
- MSB_FIRST=0, same W0 -> rd_data 0x0,0x1,...,0x7.
- LINE_ALIGN=1, line length 12 then new line -> second line's first cycle has rd_en=1 and first pixel = slice 0 of a new word; reads total 2+2. With LINE_ALIGN=0 the second line reads once at line-2 pixel 4 (cnt continues from 4).
- Hold fifo_empty=1 during the first de cycle -> underflow=1 from the next cycle, stays 1 through the frame, and clears on the next vsync rising edge.
- Pre_de=0 period with garbage on fifo_rd_data -> hdmi_rd_data=0; hsync/vsync toggles appear on Post_* exactly 2 cycles later.
- Assert sync_rst_n=0 at pixel 5 of a line, release mid-line -> all outputs 0 during reset; the first de cycle after release reads a new word, and the first output pixel is its slice 0.
